// File: rtl/ga_pkg.sv
// ga_pkg: CPU FSM state type, slot phase windows and range helper for the RAM access sequencer
package ga_pkg;
  typedef enum logic [2:0] {S_IDLE, S_PEND, S_ACCESS, S_REFRESH, S_DONE} cpu_state_e;
  localparam int CPU_SLOT_START_DEF = 8;
  localparam logic [3:0] VID_RAS_LO = 4'd1;
  localparam logic [3:0] VID_RAS_HI = 4'd6;
  localparam logic [3:0] VID_COL_LO = 4'd2;
  localparam logic [3:0] VID_COL_HI = 4'd6;
  localparam logic [3:0] VID_CAS_A_LO = 4'd2;
  localparam logic [3:0] VID_CAS_A_HI = 4'd3;
  localparam logic [3:0] VID_CAS_B_LO = 4'd5;
  localparam logic [3:0] VID_CAS_B_HI = 4'd6;
  localparam logic [3:0] VID_LAT_A = 4'd3;
  localparam logic [3:0] VID_LAT_B = 4'd6;
  localparam logic [3:0] CPU_RAS_LO = 4'd9;
  localparam logic [3:0] CPU_RAS_HI = 4'd14;
  localparam logic [3:0] REF_RAS_HI = 4'd12;
  localparam logic [3:0] CPU_COL_LO = 4'd10;
  localparam logic [3:0] CPU_COL_HI = 4'd14;
  localparam logic [3:0] CPU_CAS_LO = 4'd10;
  localparam logic [3:0] CPU_CAS_HI = 4'd13;
  localparam logic [3:0] WAIT_LAST = 4'd12;
  function automatic logic in_rng(input logic [3:0] p, input logic [3:0] lo, input logic [3:0] hi);
    return (p >= lo) && (p <= hi);
  endfunction
endpackage

// File: rtl/slot_phase_counter.sv
// slot_phase_counter: free-running 16-phase slot counter with next-phase, wrap and CPU-slot-entry decodes
module slot_phase_counter import ga_pkg::*; #(
  parameter int CPU_SLOT_START = CPU_SLOT_START_DEF
) (
  input  logic       CLK_n,
  input  logic       RESET,
  output logic [3:0] phase,
  output logic [3:0] phase_nx,
  output logic       wrap,
  output logic       slot_go
);
  localparam logic [3:0] SLOT = 4'(CPU_SLOT_START);
  logic [3:0] phase_q, phase_d;
  // next phase; wraps naturally from 15 to 0
  always_comb phase_d = phase_q + 4'd1;
  // phase register, cleared by reset
  always_ff @(posedge CLK_n) phase_q <= RESET ? 4'd0 : phase_d;
  assign phase = phase_q;
  assign phase_nx = phase_d;
  assign wrap = phase_q == 4'd15;
  assign slot_go = phase_d == SLOT;
endmodule

// File: rtl/ram_access_sequencer.sv
// ram_access_sequencer: DRAM slot sequencer sharing RAM between video fetch and Z80; WAIT_GEN_EN adds Z80 wait generation
module ram_access_sequencer import ga_pkg::*; #(
  parameter int CPU_SLOT_START = CPU_SLOT_START_DEF
) (
  input  logic       CLK_n,
  input  logic       RESET,
  input  logic       MREQ_n,
  input  logic       RFSH_n,
  input  logic       VID_EN,
  output logic [3:0] PHASE,
  output logic       RAS_n,
  output logic       CAS_n,
  output logic       MUX_COL,
  output logic       ADDR_SRC,
  output logic       VID_LATCH,
  output logic       CPU_READY
);
  logic [3:0] phase_nx;
  logic wrap, slot_go, cpu, acc;
  cpu_state_e state_q, state_d;
  logic rfsh_q, rfsh_d, vid_q, vid_d;
  logic ras_n_q, ras_n_d, cas_n_q, cas_n_d, mux_col_q, mux_col_d;
  logic addr_src_q, addr_src_d, vid_latch_q, vid_latch_d;
  slot_phase_counter #(.CPU_SLOT_START(CPU_SLOT_START)) u_phase (
    .CLK_n(CLK_n), .RESET(RESET), .phase(PHASE), .phase_nx(phase_nx), .wrap(wrap), .slot_go(slot_go)
  );
  // CPU request FSM and the video-enable latch taken at the end of each frame
  always_comb begin
    state_d = state_q;
    rfsh_d = rfsh_q;
    vid_d = wrap ? VID_EN : vid_q;
    case (state_q)
      S_IDLE: begin
        state_d = MREQ_n ? S_IDLE : S_PEND;
        rfsh_d = MREQ_n ? rfsh_q : !RFSH_n;
      end
      S_PEND: state_d = MREQ_n ? S_IDLE : slot_go ? (rfsh_q ? S_REFRESH : S_ACCESS) : S_PEND;
      S_ACCESS, S_REFRESH: state_d = wrap ? S_DONE : state_q;
      S_DONE: state_d = MREQ_n ? S_IDLE : S_DONE;
      default: state_d = S_IDLE;
    endcase
  end
  // strobes are decoded for the phase being entered so the registered outputs line up with PHASE
  always_comb begin
    cpu = (state_d == S_ACCESS) || (state_d == S_REFRESH);
    acc = state_d == S_ACCESS;
    ras_n_d = !((vid_q && in_rng(phase_nx, VID_RAS_LO, VID_RAS_HI)) ||
                (cpu && in_rng(phase_nx, CPU_RAS_LO, acc ? CPU_RAS_HI : REF_RAS_HI)));
    cas_n_d = !((vid_q && (in_rng(phase_nx, VID_CAS_A_LO, VID_CAS_A_HI) || in_rng(phase_nx, VID_CAS_B_LO, VID_CAS_B_HI))) ||
                (acc && in_rng(phase_nx, CPU_CAS_LO, CPU_CAS_HI)));
    mux_col_d = (vid_q && in_rng(phase_nx, VID_COL_LO, VID_COL_HI)) || (acc && in_rng(phase_nx, CPU_COL_LO, CPU_COL_HI));
    addr_src_d = cpu;
    vid_latch_d = vid_q && (phase_nx == VID_LAT_A || phase_nx == VID_LAT_B);
  end
  // state and output registers; reset aborts any access in progress
  always_ff @(posedge CLK_n) begin
    if (RESET) begin
      state_q <= S_IDLE;
      rfsh_q <= 1'b0;
      vid_q <= 1'b0;
      ras_n_q <= 1'b1;
      cas_n_q <= 1'b1;
      mux_col_q <= 1'b0;
      addr_src_q <= 1'b0;
      vid_latch_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rfsh_q <= rfsh_d;
      vid_q <= vid_d;
      ras_n_q <= ras_n_d;
      cas_n_q <= cas_n_d;
      mux_col_q <= mux_col_d;
      addr_src_q <= addr_src_d;
      vid_latch_q <= vid_latch_d;
    end
  end
  assign RAS_n = ras_n_q;
  assign CAS_n = cas_n_q;
  assign MUX_COL = mux_col_q;
  assign ADDR_SRC = addr_src_q;
  assign VID_LATCH = vid_latch_q;
`ifdef WAIT_GEN_EN
  logic cpu_ready_q, cpu_ready_d;
  // hold the Z80 while pending and until the serving slot's strobes are nearly done
  always_comb cpu_ready_d = !((state_d == S_PEND) || (cpu && phase_nx <= WAIT_LAST));
  // wait output register
  always_ff @(posedge CLK_n) cpu_ready_q <= RESET ? 1'b1 : cpu_ready_d;
  assign CPU_READY = cpu_ready_q;
`else
  assign CPU_READY = 1'b1;
`endif
endmodule

// File: tb/tb_ram_access_sequencer.sv
// tb_ram_access_sequencer: scoreboarded random/directed bench for ram_access_sequencer against a slot-level model
module tb_ram_access_sequencer;
  logic CLK_n = 1'b0;
  logic RESET = 1'b1, MREQ_n = 1'b1, RFSH_n = 1'b1, VID_EN = 1'b0;
  logic [3:0] PHASE;
  logic RAS_n, CAS_n, MUX_COL, ADDR_SRC, VID_LATCH, CPU_READY;
  int vectors = 0, miscompares = 0;
  logic [9:0] exp_q[$];
  int mp = 0;
  bit ven = 0, busy = 0, srv = 0, used = 0, kind = 0;

  ram_access_sequencer dut (
    .CLK_n(CLK_n), .RESET(RESET), .MREQ_n(MREQ_n), .RFSH_n(RFSH_n), .VID_EN(VID_EN),
    .PHASE(PHASE), .RAS_n(RAS_n), .CAS_n(CAS_n), .MUX_COL(MUX_COL), .ADDR_SRC(ADDR_SRC),
    .VID_LATCH(VID_LATCH), .CPU_READY(CPU_READY)
  );

  always #31 CLK_n = ~CLK_n;

  function automatic logic [9:0] expect_out();
    bit ras, cas, col, lat, rdy;
    ras = !((ven && mp inside {[1:6]}) || (srv && (kind ? mp inside {[9:12]} : mp inside {[9:14]})));
    cas = !((ven && mp inside {2, 3, 5, 6}) || (srv && !kind && mp inside {[10:13]}));
    col = (ven && mp inside {[2:6]}) || (srv && !kind && mp inside {[10:14]});
    lat = ven && mp inside {3, 6};
`ifdef WAIT_GEN_EN
    rdy = !(busy || (srv && mp <= 12));
`else
    rdy = 1'b1;
`endif
    return {4'(mp), ras, cas, col, srv, lat, rdy};
  endfunction

  task automatic step(input bit rst, input bit mreq, input bit rfsh, input bit ve);
    int np;
    @(negedge CLK_n);
    RESET = rst; MREQ_n = mreq; RFSH_n = rfsh; VID_EN = ve;
    if (rst) begin
      mp = 0; ven = 0; busy = 0; srv = 0; used = 0;
    end else begin
      np = (mp + 1) % 16;
      if (mp == 15) ven = ve;
      if (srv) begin
        if (np == 0) begin srv = 0; used = 1; end
      end else if (busy) begin
        if (mreq) busy = 0;
        else if (np == 8) begin busy = 0; srv = 1; end
      end else if (used) begin
        if (mreq) used = 0;
      end else if (!mreq) begin
        busy = 1; kind = !rfsh;
      end
      mp = np;
    end
    exp_q.push_back(expect_out());
  endtask

  task automatic cpu_req(input int ph, input bit rf, input bit ve);
    int n = 0;
    while (mp != ph) step(0, 1, 1, ve);
    while (!used && n < 80) begin step(0, 0, rf, ve); n++; end
    step(0, 1, 1, ve);
  endtask

  // monitor: every cycle the DUT presents a registered output set that is checked against the oldest prediction
  always @(posedge CLK_n) begin
    logic [9:0] e, a;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {PHASE, RAS_n, CAS_n, MUX_COL, ADDR_SRC, VID_LATCH, CPU_READY};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL outputs t=%0t got ph=%0d ras_n=%b cas_n=%b col=%b src=%b lat=%b rdy=%b expected ph=%0d ras_n=%b cas_n=%b col=%b src=%b lat=%b rdy=%b",
                 $time, a[9:6], a[5], a[4], a[3], a[2], a[1], a[0], e[9:6], e[5], e[4], e[3], e[2], e[1], e[0]);
      end
    end
  end

  initial begin
    bit m, v;
    int n;
    step(1, 1, 1, 0);
    step(1, 1, 1, 1);
    repeat (48) step(0, 1, 1, 1);
    cpu_req(4, 1, 1);
    cpu_req(9, 1, 1);
    repeat (16) step(0, 1, 1, 0);
    cpu_req(2, 0, 0);
    while (mp != 0) step(0, 1, 1, 1);
    repeat (48) step(0, 0, 1, 1);
    step(0, 1, 1, 1);
    cpu_req(4, 1, 1);
    while (mp != 3) step(0, 1, 1, 1);
    step(0, 0, 1, 1);
    step(0, 0, 1, 1);
    repeat (20) step(0, 1, 1, 1);
    while (mp != 4) step(0, 1, 1, 1);
    n = 0;
    while (!(srv && mp == 11) && n < 80) begin step(0, 0, 1, 1); n++; end
    step(1, 1, 1, 1);
    repeat (20) step(0, 1, 1, 1);
    m = 1; v = 1;
    repeat (1500) begin
      if ($urandom_range(7) == 0) m = !m;
      if ($urandom_range(15) == 0) v = !v;
      step($urandom_range(299) == 0, m, $urandom_range(1), v);
    end
    repeat (4) step(0, 1, 1, 0);
    repeat (4) @(posedge CLK_n);
    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ram_access_sequencer.md
RAM_ACCESS_SEQUENCER -- requirements
Module: ram_access_sequencer

Interface
REQ-001 Parameter: CPU_SLOT_START, 8, first phase of the CPU slot; phases below it are the video slot.
REQ-002 CLK_n  in  1  16 MHz system clock; all state updates on its rising edge.
REQ-003 RESET  in  1  synchronous, active-high reset.
REQ-004 MREQ_n  in  1  Z80 memory request, active low.
REQ-005 RFSH_n  in  1  Z80 refresh indicator, active low.
REQ-006 VID_EN  in  1  video fetch enable from the CRTC interface, sampled at phase 15.
REQ-007 PHASE  out  4  current slot phase, 0..15.
REQ-008 RAS_n  out  1  DRAM row strobe, active low.
REQ-009 CAS_n  out  1  DRAM column strobe, active low.
REQ-010 MUX_COL  out  1  address mux select: 0 = row, 1 = column.
REQ-011 ADDR_SRC  out  1  address source: 0 = video, 1 = CPU.
REQ-012 VID_LATCH  out  1  one-cycle pulse that latches a video byte.
REQ-013 CPU_READY  out  1  Z80 WAIT_n, active low.

Function
REQ-014 PHASE SHALL increment every cycle and wrap from 15 to 0.
REQ-015 All outputs SHALL be registered, and the values stated here SHALL be the values held during the stated phase.
REQ-016 Video slot, when VID_EN was 1 at the preceding phase 15:
- RAS_n low in phases 1-6.
- MUX_COL high in phases 2-6.
- CAS_n low in phases 2-3 and 5-6.
- VID_LATCH high in phases 3 and 6.
- ADDR_SRC = 0 throughout.
REQ-017 Video slot, when VID_EN was 0 at the preceding phase 15: the slot SHALL be idle, with no strobes and no VID_LATCH.
REQ-018 CPU FSM states: IDLE, PEND, ACCESS, REFRESH, DONE.
REQ-019 IDLE -> PEND when MREQ_n = 0 at any edge. The request kind (read/write vs refresh, from RFSH_n) SHALL be captured at that edge.
REQ-020 PEND -> ACCESS or REFRESH only at the edge entering phase CPU_SLOT_START.
- A request registered at that same edge or later SHALL wait for the next frame.
REQ-021 ACCESS (phases 8-15):
- ADDR_SRC = 1.
- RAS_n low in phases 9-14.
- MUX_COL high in phases 10-14.
- CAS_n low in phases 10-13.
REQ-022 REFRESH: RAS_n low in phases 9-12; CAS_n and MUX_COL high; ADDR_SRC = 1.
REQ-023 ACCESS/REFRESH -> DONE at the edge entering phase 0.
REQ-024 DONE -> IDLE when MREQ_n = 1; DONE SHALL grant exactly one access per MREQ_n assertion.
REQ-025 MREQ_n deasserting while in PEND SHALL return the FSM to IDLE with no access issued.
REQ-026 Video and CPU strobes SHALL never overlap. RAS_n SHALL be high for at least phases 7-8 and 15-0 (precharge).
REQ-027 ADDR_SRC SHALL be 0 in phases 0-7 and in idle CPU slots.

Reset
REQ-028 A rising edge with RESET = 1 SHALL set:
- PHASE = 0 and FSM = IDLE.
- RAS_n = 1, CAS_n = 1.
- MUX_COL = 0, ADDR_SRC = 0, VID_LATCH = 0.
- CPU_READY = 1.
- Video-enable latch = 0.
REQ-029 Reset asserted mid-access SHALL abort the access at that edge; strobes high the following cycle; no residual request.
REQ-030 After reset release, the first video fetch SHALL occur no earlier than phase 1 of the second frame.

Configuration
REQ-031 With macro WAIT_GEN_EN defined, CPU_READY SHALL be 0:
- from the cycle after entry to PEND, and
- through phase 12 of the serving ACCESS/REFRESH slot,
- and 1 at all other times.
REQ-032 Without WAIT_GEN_EN, CPU_READY SHALL be constant 1 and no wait logic SHALL be synthesised.

Structure
REQ-033 A shared package ga_pkg SHALL hold:
- the CPU FSM state enum;
- phase constants (video RAS/CAS/latch windows, CPU RAS/CAS windows, CPU_SLOT_START default).
REQ-034 One sub-module, slot_phase_counter, SHALL provide PHASE and per-phase decode strobes. The FSM and strobe generation SHALL reside in ram_access_sequencer.

Verification
REQ-035 VID_EN = 1 held, no CPU requests -> each frame: CAS_n low at phases 2,3,5,6; VID_LATCH at phases 3,6; ADDR_SRC = 0 throughout.
REQ-036 MREQ_n low at phase 4, RFSH_n = 1 -> ACCESS in phases 8-15 of the same frame, CAS_n low at phases 10-13. With WAIT_GEN_EN: CPU_READY low at phases 5-12.
REQ-037 MREQ_n low at phase 9 -> no CPU strobes that frame; access in phases 8-15 of the next frame.
REQ-038 MREQ_n low, RFSH_n = 0 at phase 2 -> RAS_n low at phases 9-12, CAS_n high for the entire frame.
REQ-039 MREQ_n held low for 3 frames -> exactly one ACCESS; a second access only after MREQ_n goes high then low again.
REQ-040 RESET pulsed at phase 11 of an ACCESS -> next cycle: RAS_n = CAS_n = 1, PHASE = 0, CPU_READY = 1, FSM = IDLE.
